switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer.sv | 109 ++++++++++
 tb/tb_switch_debouncer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Multi-bit switch debouncer: two-flop synchronizer, shared tick prescaler and
// per-bit saturating persistence counters. Define SWITCH_DEBOUNCER_EDGE_EN to build edge strobes.
module switch_debouncer #(
    parameter int WIDTH          = 10,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int PRESCALE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0]         sync1_q;
    logic [WIDTH-1:0]         sync2_q;
    logic [WIDTH-1:0]         out_q;
    logic [WIDTH-1:0]         out_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0][CW-1:0] cnt_d;
    logic [PW-1:0]            pre_q;
    logic [PW-1:0]            pre_d;
    logic                     tick_s;

    // Two-flop synchronizer for the raw pad levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
        end
    end

    // Prescaler next state; a count of PRESCALE-1 is the tick and wraps to zero.
    always_comb begin
        tick_s = (pre_q == PRE_LAST);
        if (tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    // Per-bit persistence counters: agreement clears at once, disagreement advances on ticks only.
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_s) begin
                if (cnt_q[i] == CNT_LAST) begin
                    out_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out_port = out_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // Strobes register alongside out_q so they coincide with the accepted change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= out_d & ~out_q;
            fall_q <= out_q & ~out_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    assign rise_pulse = '0;
    assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench: two debouncer instances (PRESCALE 1 and 3) against a
// behavioural model, directed latency/glitch/reset steps plus randomized holds.
module tb_switch_debouncer;

    localparam int W   = 10;
    localparam int DEB = 4;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic         clk;
    logic         reset_n;
    logic [W-1:0] sw_in;
    logic [W-1:0] out1, rise1, fall1;
    logic [W-1:0] out3, rise3, fall3;

    int tests = 0;
    int fails = 0;

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_TICKS(DEB), .PRESCALE(1)) dut (
        .clk(clk), .reset_n(reset_n), .sw_in(sw_in),
        .out_port(out1), .rise_pulse(rise1), .fall_pulse(fall1)
    );

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_TICKS(DEB), .PRESCALE(3)) dut_p3 (
        .clk(clk), .reset_n(reset_n), .sw_in(sw_in),
        .out_port(out3), .rise_pulse(rise3), .fall_pulse(fall3)
    );

    always #5 clk = ~clk;

    // Reference model: k=0 is the PRESCALE=1 instance, k=1 the PRESCALE=3 one.
    int           pre_n [2] = '{1, 3};
    int           pc    [2];
    int           run   [2][W];
    logic [W-1:0] ms1 [2], ms2 [2], mout [2], mrise [2], mfall [2];

    function automatic logic [W-1:0] exp_pulse(input logic [W-1:0] v);
        return EDGE_ON ? v : {W{1'b0}};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            pc[k] = 0; ms1[k] = '0; ms2[k] = '0; mout[k] = '0; mrise[k] = '0; mfall[k] = '0;
            for (int b = 0; b < W; b++) run[k][b] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        bit tk;
        tk = (pc[k] == pre_n[k] - 1);
        pc[k] = tk ? 0 : pc[k] + 1;
        mrise[k] = '0;
        mfall[k] = '0;
        for (int b = 0; b < W; b++) begin
            if (ms2[k][b] == mout[k][b]) run[k][b] = 0;
            else if (tk) begin
                run[k][b] = run[k][b] + 1;
                if (run[k][b] >= DEB) begin
                    mout[k][b] = ms2[k][b];
                    if (ms2[k][b]) mrise[k][b] = 1'b1;
                    else           mfall[k][b] = 1'b1;
                    run[k][b] = 0;
                end
            end
        end
        ms2[k] = ms1[k];
        ms1[k] = sw_in;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("p1_out",  out1,  mout[0]);
        check("p1_rise", rise1, exp_pulse(mrise[0]));
        check("p1_fall", fall1, exp_pulse(mfall[0]));
        check("p3_out",  out3,  mout[1]);
        check("p3_rise", rise3, exp_pulse(mrise[1]));
        check("p3_fall", fall3, exp_pulse(mfall[1]));
    endtask

    task automatic step();
        if (reset_n) begin
            model_edge(0);
            model_edge(1);
        end else begin
            model_clear();
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic settle(input logic [W-1:0] v);
        sw_in = v;
        repeat (20) step();
    endtask

    initial begin
        int rise5;
        int trans5;
        logic prev5;

        clk = 1'b0;
        reset_n = 1'b0;
        sw_in = 10'h3FF;
        model_clear();
        #2;
        check("rst_out", out1, 10'h000);
        check("rst_rise", rise1, 10'h000);
        repeat (3) step();
        check("rst_hold_out", out1, 10'h000);

        // All-ones at release: edge 6 for PRESCALE=1, edge 12 for PRESCALE=3.
        reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 5)  check("lat_e5_out", out1, 10'h000);
            if (i == 6) begin
                check("lat_e6_out", out1, 10'h3FF);
                check("lat_e6_rise", rise1, exp_pulse(10'h3FF));
            end
            if (i == 7)  check("lat_e7_rise", rise1, 10'h000);
            if (i == 11) check("p3_e11_out", out3, 10'h000);
            if (i == 12) check("p3_e12_out", out3, 10'h3FF);
        end

        // Short 3-cycle glitch rejected, longer hold accepted.
        settle(10'h000);
        sw_in = 10'h001;
        repeat (3) step();
        sw_in = 10'h000;
        repeat (10) step();
        check("glitch_out", out1, 10'h000);
        sw_in = 10'h001;
        repeat (8) step();
        check("hold_out", out1, 10'h001);

        // Bit 5 chatter then steady high: one transition, one strobe.
        settle(10'h000);
        rise5 = 0;
        trans5 = 0;
        prev5 = out1[5];
        for (int t = 0; t < 10; t++) begin
            sw_in[5] = ~sw_in[5];
            repeat (2) begin
                step();
                if (rise1[5]) rise5++;
                if (out1[5] != prev5) trans5++;
                prev5 = out1[5];
            end
        end
        sw_in[5] = 1'b1;
        repeat (12) begin
            step();
            if (rise1[5]) rise5++;
            if (out1[5] != prev5) trans5++;
            prev5 = out1[5];
        end
        check("chatter_trans", W'(trans5), W'(1));
        check("chatter_rise", W'(rise5), W'(EDGE_ON ? 1 : 0));
        check("chatter_out", out1, 10'h020);

        // Simultaneous rise and fall on different bits.
        settle(10'h004);
        sw_in = 10'h002;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) check("swap_e5_out", out1, 10'h004);
            if (i == 6) begin
                check("swap_e6_out", out1, 10'h002);
                check("swap_e6_rise", rise1, exp_pulse(10'h002));
                check("swap_e6_fall", fall1, exp_pulse(10'h004));
            end
        end

        // Reset in the middle of a count discards it.
        settle(10'h000);
        sw_in = 10'h3FF;
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        model_clear();
        compare_all();
        check("midrst_out", out1, 10'h000);
        repeat (2) step();
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) check("midrst_e5_out", out1, 10'h000);
            if (i == 6) check("midrst_e6_out", out1, 10'h3FF);
        end

        // Randomized holds with occasional resets.
        for (int n = 0; n < 200; n++) begin
            sw_in = sw_in ^ W'($urandom);
            repeat ($urandom_range(1, 8)) step();
            if ($urandom_range(0, 19) == 0) begin
                reset_n = 1'b0;
                #1;
                model_clear();
                compare_all();
                step();
                reset_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
